sram_dual_responder: RTL and testbench
======================================

Name: sram_dual_responder

Overview:
- Memory-side responder for the CPU core's two SRAM-style initiator ports: instruction fetch (read-only) and data (read/write, byte enables).
- Holds one shared word array; both ports return read data one cycle after the request.
- Zero-fills the array after reset through a clear state machine.
- Detects and logs out-of-range accesses for debug.
- Sits directly under the SoC top, in place of the external inst/data RAMs.

Parameters:
ADDR_WIDTH, 12, word-address width; DEPTH = 2^ADDR_WIDTH words
BASE_ADDR, 32'h1c000000, byte address of word 0 (must be 4-byte aligned)
CLEAR_ON_RESET, 1, 1 = zero-fill array after reset; 0 = go straight to READY

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
inst_sram_en  input  1  instruction read request
inst_sram_we  input  4  must be 0; any nonzero value is an error
inst_sram_addr  input  32  byte address of instruction
inst_sram_wdata  input  32  ignored
inst_sram_rdata  output  32  instruction word, 1 cycle after request
data_sram_en  input  1  data request
data_sram_we  input  4  byte-lane write enables; 0 = read
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
data_sram_rdata  output  32  data word, 1 cycle after request
busy  output  1  clear in progress; requests ignored
err_cnt  output  16  saturating count of error events
err_valid  output  1  sticky; set on first error
err_addr  output  32  address of first error

Behaviour:
- Reset values:
  - inst_sram_rdata = 0, data_sram_rdata = 0, err_cnt = 0, err_valid = 0, err_addr = 0.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET = 1, else READY.
- States: CLEAR, READY.
  - CLEAR: each cycle write 0 to word[clr_cnt], then clr_cnt++.
  - When clr_cnt = DEPTH-1 is written, go to READY on the next edge. CLEAR lasts exactly DEPTH cycles.
  - busy = (state == CLEAR).
  - reset asserted at any time, including mid-clear: state -> CLEAR (or READY), clr_cnt -> 0. Array contents are not otherwise touched by reset.
- In CLEAR:
  - All port requests are ignored: no writes, not counted as errors.
  - rdata registers load 0 for any request.
- Address decode:
  - off = addr - BASE_ADDR (32-bit, wraps).
  - In range iff off < 4*DEPTH. Word index = off[ADDR_WIDTH+1:2]. addr[1:0] ignored.
- Read (READY, en = 1):
  - rdata <= word[index] at the edge; visible in the next cycle.
  - rdata holds its last value whenever en = 0.
- Write (READY, data en = 1, we != 0, in range):
  - For each lane i with we[i] = 1: word[index] lane i <= wdata lane i. Other lanes unchanged.
  - data_sram_rdata for a write cycle loads the OLD word (read-first).
- Same-cycle collision (data write, inst read, same index): inst_sram_rdata returns the OLD word; the write commits. A data write followed next cycle by a read returns the new value.
- Error events (READY only):
  - Any port with en = 1 and out-of-range address: write dropped, rdata <= 0.
  - inst_sram_en = 1 with inst_sram_we != 0: treated as a read; still an error.
  - Each port contributes at most 1 per cycle. err_cnt += (0..2), saturating at 16'hFFFF.
  - First error sets err_valid = 1 and latches err_addr. If both ports error in the same cycle, the data port address wins.
  - err_valid and err_addr hold until reset.
- No backpressure: both ports accept one request per cycle, every cycle, in READY.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, ADDR_WIDTH = 4 -> busy = 1 for exactly 16 cycles then 0; reading every word returns 32'h0.
- Data write we = 4'b1111, addr = BASE+8, wdata = 32'hDEADBEEF, then read BASE+8 -> rdata = 32'hDEADBEEF in the cycle after the read.
- Then write we = 4'b0010, wdata = 32'h0000AA00 to the same address, then read -> rdata = 32'hDEADAAEF.
- Same cycle: data write 32'h12345678 and inst read to BASE+4 (old 0) -> inst_sram_rdata = 0; inst read next cycle -> 32'h12345678.
- Data read at BASE+64 (DEPTH = 16), then inst read at BASE-4 -> both rdata = 0, err_cnt = 2, err_valid = 1, err_addr = BASE+64.
- Assert reset for 1 cycle mid-clear (clr_cnt = 7) -> busy stays 1 for 16 more cycles; error registers = 0; a write issued during busy is not stored (read back = 0).

Source files
------------

// File: rtl/sram_dual_responder.sv
// Shared-word SRAM responder for the core's instruction-fetch and data ports.
// Single-cycle read latency on both ports, zero-fill after reset, out-of-range error logging.
module sram_dual_responder #(
    parameter int          ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h1c000000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        busy,
    output logic [15:0] err_cnt,
    output logic        err_valid,
    output logic [31:0] err_addr
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Request/response contract: a port request is accepted whenever en = 1
    // (there is no ready); its rdata is valid in the cycle after the request
    // and holds until the next request on that port.

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_we;

    logic [31:0] mem [DEPTH];

    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0]           inst_off, data_off;
    logic                  inst_in_range, data_in_range;
    logic [ADDR_WIDTH-1:0] inst_idx, data_idx;
    logic                  ready;
    logic                  inst_err, data_err, data_wr;
    logic [16:0]           err_sum;
    logic                  unused_ok;

    // The subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign inst_off      = inst_sram_addr - BASE_ADDR;
    assign data_off      = data_sram_addr - BASE_ADDR;
    assign inst_in_range = (inst_off[31:ADDR_WIDTH+2] == '0);
    assign data_in_range = (data_off[31:ADDR_WIDTH+2] == '0);
    assign inst_idx      = inst_off[ADDR_WIDTH+1:2];
    assign data_idx      = data_off[ADDR_WIDTH+1:2];

    assign ready    = (state_q == ST_READY);
    assign inst_err = ready && inst_sram_en && (!inst_in_range || (inst_sram_we != 4'b0000));
    assign data_err = ready && data_sram_en && !data_in_range;
    assign data_wr  = ready && data_sram_en && data_in_range && (data_sram_we != 4'b0000);

    assign unused_ok = ^{inst_sram_wdata, inst_off[1:0], data_off[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Array has no reset; the clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (data_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_sram_we[i]) begin
                        mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (inst_sram_en) begin
            inst_rdata_d = (ready && inst_in_range) ? mem[inst_idx] : 32'h0;
        end
        if (data_sram_en) begin
            data_rdata_d = (ready && data_in_range) ? mem[data_idx] : 32'h0;
        end
    end

    assign err_sum   = 17'(err_cnt_q) + 17'(inst_err) + 17'(data_err);
    assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (!err_valid_q && (inst_err || data_err)) begin
            err_valid_d = 1'b1;
            err_addr_d  = data_err ? data_sram_addr : inst_sram_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            err_cnt_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            err_cnt_q    <= err_cnt_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign busy            = (state_q == ST_CLEAR);
    assign err_cnt         = err_cnt_q;
    assign err_valid       = err_valid_q;
    assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_sram_dual_responder.sv
// Self-checking bench for sram_dual_responder (ADDR_WIDTH = 4): clear timing,
// byte-lane writes, read-first collisions, error logging and mid-clear reset.
module tb_sram_dual_responder;
    localparam int          AW   = 4;
    localparam logic [31:0] BASE = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_we = '0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_wdata = '0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_we = '0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [31:0] data_sram_rdata;
    logic        busy;
    logic [15:0] err_cnt;
    logic        err_valid;
    logic [31:0] err_addr;

    sram_dual_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .busy(busy), .err_cnt(err_cnt), .err_valid(err_valid), .err_addr(err_addr)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state and reference model
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] model_mem [16];
    logic        model_busy = 1'b1;
    logic [15:0] model_err_cnt = '0;
    logic        model_err_valid = 1'b0;
    logic [31:0] model_err_addr = '0;
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'd64;
    endfunction

    function automatic logic [3:0] model_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off[5:2];
    endfunction

    // One clock of traffic: predict, drive, step, then pop and compare.
    task automatic cycle(input logic ie, input logic [3:0] iwe, input logic [31:0] ia,
                         input logic de, input logic [3:0] dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        logic ierr, derr;
        logic [16:0] sum;
        ierr = 1'b0;
        derr = 1'b0;
        if (ie) begin
            if (!model_busy && model_in_range(ia)) exp_inst_q.push_back(model_mem[model_idx(ia)]);
            else exp_inst_q.push_back(32'h0);
            ierr = !model_busy && (!model_in_range(ia) || (iwe != 4'b0000));
        end
        if (de) begin
            if (!model_busy && model_in_range(da)) exp_data_q.push_back(model_mem[model_idx(da)]);
            else exp_data_q.push_back(32'h0);
            derr = !model_busy && !model_in_range(da);
            if (!model_busy && model_in_range(da)) begin
                for (int l = 0; l < 4; l++)
                    if (dwe[l]) model_mem[model_idx(da)][8*l +: 8] = dwd[8*l +: 8];
            end
        end
        sum = {1'b0, model_err_cnt} + 17'(ierr) + 17'(derr);
        model_err_cnt = (sum > 17'h0FFFF) ? 16'hFFFF : sum[15:0];
        if (!model_err_valid && (ierr || derr)) begin
            model_err_valid = 1'b1;
            model_err_addr = derr ? da : ia;
        end
        inst_sram_en = ie; inst_sram_we = iwe; inst_sram_addr = ia;
        inst_sram_wdata = $urandom;
        data_sram_en = de; data_sram_we = dwe; data_sram_addr = da; data_sram_wdata = dwd;
        @(posedge clk);
        #1;
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        if (ie && exp_inst_q.size() > 0) check("inst_rdata", inst_sram_rdata, exp_inst_q.pop_front());
        if (de && exp_data_q.size() > 0) check("data_rdata", data_sram_rdata, exp_data_q.pop_front());
        check("busy", 32'(busy), 32'(model_busy));
        check("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
        check("err_valid", 32'(err_valid), 32'(model_err_valid));
        check("err_addr", err_addr, model_err_addr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_busy = 1'b1;
        model_err_cnt = '0;
        model_err_valid = 1'b0;
        model_err_addr = '0;
        for (int k = 0; k < 16; k++) model_mem[k] = 32'h0;
        check("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("rst_data_rdata", data_sram_rdata, 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_err_valid", 32'(err_valid), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
    endtask

    // Count the remaining busy cycles, bounded so a stuck clear cannot hang the run.
    task automatic wait_ready(input int expected);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_cycles", 32'(n), 32'(expected));
        model_busy = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return BASE + {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        // Power-up clear
        do_reset(2);
        wait_ready(16);

        // Every word reads back zero on both ports
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'h0, BASE + 32'(4*i), 1'b1, 4'h0, BASE + 32'(4*(15-i)), 32'h0);

        // Full-word write, then byte-lane merge
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'b1111, BASE + 32'd8, 32'hDEADBEEF);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'b0000, BASE + 32'd8, 32'h0);
        check("full_write", data_sram_rdata, 32'hDEADBEEF);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'b0010, BASE + 32'd8, 32'h0000AA00);
        cycle(1'b1, 4'h0, BASE + 32'd8, 1'b1, 4'b0000, BASE + 32'd8, 32'h0);
        check("lane_merge", data_sram_rdata, 32'hDEADAAEF);

        // Same-cycle data write and inst read: inst sees the old word, then the new one
        cycle(1'b1, 4'h0, BASE + 32'd4, 1'b1, 4'b1111, BASE + 32'd4, 32'h12345678);
        check("collision_old", inst_sram_rdata, 32'h0);
        cycle(1'b1, 4'h0, BASE + 32'd4, 1'b0, 4'h0, 32'h0, 32'h0);
        check("collision_new", inst_sram_rdata, 32'h12345678);

        // rdata holds with en low
        idle(2);
        check("hold_inst", inst_sram_rdata, 32'h12345678);

        // Random in-range traffic on both ports
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 4'h0, rand_addr(),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);

        // Error logging
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + 32'd64, 32'h0);
        cycle(1'b1, 4'h0, BASE - 32'd4, 1'b0, 4'h0, 32'h0, 32'h0);
        check("oor_inst_rdata", inst_sram_rdata, 32'h0);
        check("err_cnt_two", 32'(err_cnt), 32'd2);
        check("err_addr_first", err_addr, BASE + 32'd64);
        cycle(1'b1, 4'b0001, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, BASE + 32'd100, 1'b1, 4'b1111, BASE + 32'd72, 32'hCAFEF00D);
        check("err_cnt_dual", 32'(err_cnt), 32'd5);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE + 32'd8, 32'h0);

        // Reset mid-clear restarts the full clear; traffic during busy is ignored
        do_reset(1);
        idle(7);
        do_reset(1);
        idle(4);
        cycle(1'b1, 4'h0, BASE + 32'd128, 1'b1, 4'b1111, BASE, 32'hDEADBEEF);
        check("busy_data_rdata", data_sram_rdata, 32'h0);
        wait_ready(11);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, BASE, 32'h0);
        check("busy_write_dropped", data_sram_rdata, 32'h0);

        check("queues_drained", 32'(exp_inst_q.size() + exp_data_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
